// File: rtl/pueo_leveltwo_pkg.sv
// Shared definitions for the PUEO level-two trigger.
//   NPOL / HPOL / VPOL      : polarization count and indices
//   NSECT_DEFAULT, NREGION_DEFAULT : default array geometry
//   LATENCY                 : ce edges from input sample to trig_o / leveltwo_o
//   L2_BASE, LF_BASE, AUX_BIT : bit positions inside trig_src_o
//   l2_state_e              : master trigger FSM states
package pueo_leveltwo_pkg;

    localparam int NPOL            = 2;
    localparam int HPOL            = 0;
    localparam int VPOL            = 1;
    localparam int NSECT_DEFAULT   = 12;
    localparam int NREGION_DEFAULT = 4;
    localparam int LATENCY         = 3;

    localparam int L2_BASE    = 0;
    localparam int LF_BASE    = NPOL;
    localparam int AUX_BIT    = 2 * NPOL;
    localparam int TRIG_SRC_W = 2 * NPOL + 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HOLDOFF = 1'b1
    } l2_state_e;

endpackage

// File: rtl/pueo_l2_stretch.sv
// Vector of retriggerable pulse stretchers.
//   clk_i, rst_i : clock and synchronous active-high reset
//   ce_i         : clock enable; all state holds when low
//   window_i     : stretch window in ce cycles, clamped to MAX_WINDOW
//   d_i          : input bits
//   q_o          : stretched bits; a hit stays high for window+1 ce cycles
//                  after the last hit
module pueo_l2_stretch
    import pueo_leveltwo_pkg::*;
#(
    parameter int WIDTH      = 48,
    parameter int MAX_WINDOW = 15,
    localparam int WIN_W     = $clog2(MAX_WINDOW + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic [WIN_W-1:0] window_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] in_d;
    logic [WIN_W-1:0] cnt_q [WIDTH];
    logic [WIN_W-1:0] cnt_d [WIDTH];
    logic [WIN_W-1:0] win_clamped;

    always_comb begin
        win_clamped = (window_i > WIN_W'(MAX_WINDOW)) ? WIN_W'(MAX_WINDOW) : window_i;
    end

    // The counter loads from the registered input so that in_q covers the
    // first cycle and the counter covers the following `window` cycles.
    always_comb begin
        in_d = ce_i ? d_i : in_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (ce_i) begin
                if (in_q[i]) begin
                    cnt_d[i] = win_clamped;
                end else if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - WIN_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            q_o[i] = in_q[i] | (cnt_q[i] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            in_q <= in_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: rtl/pueo_leveltwo_coinc.sv
// PUEO level-two trigger: stretch low/high band metadata, form the
// low(s) & high(s+1) coincidence per sector, merge with LF and aux into a
// master trigger with dead gating and programmable holdoff.
//   clk_i, rst_i, ce_i : clock, synchronous active-high reset, clock enable
//   low_i, high_i      : band metadata, bit ((p*NSECT)+s)*NREGION+r
//   lf_i, aux_i        : LF per polarization, OR of aux triggers
//   window_i           : stretch window
//   sect_mask_i        : 1 excludes sector p*NSECT+s from coincidence
//   holdoff_len_i      : holdoff after a trigger, in ce cycles (0 = none)
//   dead_i             : drops triggers while high
//   meta_i / meta_o    : metadata, delayed to align with trig_o
//   leveltwo_o         : per-sector coincidence pulses
//   trig_src_o         : {aux, lf, l2} captured with the last trigger
//   trig_o             : master trigger pulse
module pueo_leveltwo_coinc
    import pueo_leveltwo_pkg::*;
#(
    parameter int NSECT      = NSECT_DEFAULT,
    parameter int NREGION    = NREGION_DEFAULT,
    parameter int MAX_WINDOW = 15,
    parameter int META_W     = 256,
    parameter int HOLDOFF_W  = 16,
    localparam int WIN_W     = $clog2(MAX_WINDOW + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ce_i,
    input  logic [NPOL*NSECT*NREGION-1:0] low_i,
    input  logic [NPOL*NSECT*NREGION-1:0] high_i,
    input  logic [NPOL-1:0]               lf_i,
    input  logic                          aux_i,
    input  logic [WIN_W-1:0]              window_i,
    input  logic [NPOL*NSECT-1:0]         sect_mask_i,
    input  logic [HOLDOFF_W-1:0]          holdoff_len_i,
    input  logic                          dead_i,
    input  logic [META_W-1:0]             meta_i,
    output logic [META_W-1:0]             meta_o,
    output logic [NPOL*NSECT-1:0]         leveltwo_o,
    output logic [TRIG_SRC_W-1:0]         trig_src_o,
    output logic                          trig_o
);

    localparam int NPS = NSECT * NREGION;
    localparam int NB  = NPOL * NPS;
    localparam int NCS = NPOL * NSECT;

    logic [NB-1:0] low_s;
    logic [NB-1:0] high_s;

    for (genvar p = 0; p < NPOL; p++) begin : g_pol
        pueo_l2_stretch #(
            .WIDTH      (NPS),
            .MAX_WINDOW (MAX_WINDOW)
        ) u_low (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .ce_i     (ce_i),
            .window_i (window_i),
            .d_i      (low_i[p*NPS +: NPS]),
            .q_o      (low_s[p*NPS +: NPS])
        );

        pueo_l2_stretch #(
            .WIDTH      (NPS),
            .MAX_WINDOW (MAX_WINDOW)
        ) u_high (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .ce_i     (ce_i),
            .window_i (window_i),
            .d_i      (high_i[p*NPS +: NPS]),
            .q_o      (high_s[p*NPS +: NPS])
        );
    end

    // Stage 2: sector s low band against sector s+1 high band, wrapping.
    logic [NCS-1:0] sect_hit;

    always_comb begin
        sect_hit = '0;
        for (int p = 0; p < NPOL; p++) begin
            for (int s = 0; s < NSECT; s++) begin
                for (int r = 0; r < NREGION; r++) begin
                    sect_hit[p*NSECT+s] = sect_hit[p*NSECT+s]
                        | (low_s[(p*NSECT+s)*NREGION+r]
                           & high_s[(p*NSECT+((s+1)%NSECT))*NREGION+r]);
                end
            end
        end
    end

    logic [NCS-1:0]        coinc_q,    coinc_d;
    logic [NCS-1:0]        coinc_s3_q, coinc_s3_d;
    logic [NPOL-1:0]       l2_q,       l2_d;
    logic [NPOL-1:0]       lf_d1_q,    lf_d1_d;
    logic [NPOL-1:0]       lf_d2_q,    lf_d2_d;
    logic [NPOL-1:0]       lf_s3_q,    lf_s3_d;
    logic                  aux_d1_q,   aux_d1_d;
    logic                  aux_d2_q,   aux_d2_d;
    logic                  aux_s3_q,   aux_s3_d;
    logic [NCS-1:0]        leveltwo_q, leveltwo_d;
    logic [META_W-1:0]     meta_q [LATENCY+1];
    logic [META_W-1:0]     meta_d [LATENCY+1];

    // Pipeline next-state: everything holds unless ce_i, except the
    // leveltwo pulse which clears on the non-ce clock.
    always_comb begin
        coinc_d    = coinc_q;
        coinc_s3_d = coinc_s3_q;
        l2_d       = l2_q;
        lf_d1_d    = lf_d1_q;
        lf_d2_d    = lf_d2_q;
        lf_s3_d    = lf_s3_q;
        aux_d1_d   = aux_d1_q;
        aux_d2_d   = aux_d2_q;
        aux_s3_d   = aux_s3_q;
        leveltwo_d = '0;
        for (int i = 0; i <= LATENCY; i++) begin
            meta_d[i] = meta_q[i];
        end
        if (ce_i) begin
            coinc_d    = sect_hit & ~sect_mask_i;
            coinc_s3_d = coinc_q;
            for (int p = 0; p < NPOL; p++) begin
                l2_d[p] = |coinc_q[p*NSECT +: NSECT];
            end
            lf_d1_d    = lf_i;
            lf_d2_d    = lf_d1_q;
            lf_s3_d    = lf_d2_q;
            aux_d1_d   = aux_i;
            aux_d2_d   = aux_d1_q;
            aux_s3_d   = aux_d2_q;
            leveltwo_d = coinc_s3_q;
            meta_d[0]  = meta_i;
            for (int i = 1; i <= LATENCY; i++) begin
                meta_d[i] = meta_q[i-1];
            end
        end
    end

    // Master trigger FSM.
    // state      | meaning
    // ST_IDLE    | armed; any live source fires trig_o
    // ST_HOLDOFF | counting down hcnt; sources are dropped
    l2_state_e               state_q,    state_d;
    logic [HOLDOFF_W-1:0]    hcnt_q,     hcnt_d;
    logic                    trig_q,     trig_d;
    logic [TRIG_SRC_W-1:0]   trig_src_q, trig_src_d;
    logic [TRIG_SRC_W-1:0]   src_now;

    always_comb begin
        src_now                   = '0;
        src_now[L2_BASE +: NPOL]  = l2_q;
        src_now[LF_BASE +: NPOL]  = lf_s3_q;
        src_now[AUX_BIT]          = aux_s3_q;
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        trig_d     = 1'b0;
        trig_src_d = trig_src_q;
        if (ce_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dead_i && (src_now != '0)) begin
                        trig_d     = 1'b1;
                        trig_src_d = src_now;
                        if (holdoff_len_i != '0) begin
                            hcnt_d  = holdoff_len_i;
                            state_d = ST_HOLDOFF;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    // hcnt never wraps: leaving at 1 frees the next ce cycle.
                    if (hcnt_q <= HOLDOFF_W'(1)) begin
                        hcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        hcnt_d = hcnt_q - HOLDOFF_W'(1);
                    end
                end
                default: begin
                    hcnt_d  = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            coinc_q    <= '0;
            coinc_s3_q <= '0;
            l2_q       <= '0;
            lf_d1_q    <= '0;
            lf_d2_q    <= '0;
            lf_s3_q    <= '0;
            aux_d1_q   <= 1'b0;
            aux_d2_q   <= 1'b0;
            aux_s3_q   <= 1'b0;
            leveltwo_q <= '0;
            for (int i = 0; i <= LATENCY; i++) begin
                meta_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            hcnt_q     <= '0;
            trig_q     <= 1'b0;
            trig_src_q <= '0;
        end else begin
            coinc_q    <= coinc_d;
            coinc_s3_q <= coinc_s3_d;
            l2_q       <= l2_d;
            lf_d1_q    <= lf_d1_d;
            lf_d2_q    <= lf_d2_d;
            lf_s3_q    <= lf_s3_d;
            aux_d1_q   <= aux_d1_d;
            aux_d2_q   <= aux_d2_d;
            aux_s3_q   <= aux_s3_d;
            leveltwo_q <= leveltwo_d;
            for (int i = 0; i <= LATENCY; i++) begin
                meta_q[i] <= meta_d[i];
            end
            state_q    <= state_d;
            hcnt_q     <= hcnt_d;
            trig_q     <= trig_d;
            trig_src_q <= trig_src_d;
        end
    end

    assign meta_o     = meta_q[LATENCY];
    assign leveltwo_o = leveltwo_q;
    assign trig_src_o = trig_src_q;
    assign trig_o     = trig_q;

endmodule
